// File: rtl/ram_loader.sv
// Framed byte-stream loader: takes len/payload/checksum from the UART receiver,
// writes the payload to RAM addresses 0..N-1 and holds the CPU while a frame is in flight.
module ram_loader #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_valid,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_d_in,
  output logic                  busy,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  err
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LEN  = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_CSUM = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;
  localparam logic [2:0] S_ERR  = 3'd5;

  // Count/index carry one extra bit so a zero length byte means a full 2^ADDR_WIDTH frame.
  localparam int CW = ADDR_WIDTH + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [2:0]            state_q,    state_d;
  logic [CW-1:0]         count_q,    count_d;
  logic [CW-1:0]         index_q,    index_d;
  logic [DATA_WIDTH-1:0] sum_q,      sum_d;
  logic [TW-1:0]         timer_q,    timer_d;
  logic                  ram_we_q,   ram_we_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0] ram_d_in_q, ram_d_in_d;
  logic                  busy_q,     busy_d;
  logic                  done_q,     done_d;
  logic                  err_q,      err_d;
  logic [DATA_WIDTH-1:0] csum_total;

  // rx_valid is a one-cycle strobe with no back-pressure: every strobe seen in
  // LEN/DATA/CSUM is consumed in that cycle; strobes in IDLE/DONE/ERR are dropped.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    index_d    = index_q;
    sum_d      = sum_q;
    timer_d    = timer_q;
    ram_we_d   = 1'b0;
    ram_addr_d = ram_addr_q;
    ram_d_in_d = ram_d_in_q;
    busy_d     = busy_q;
    done_d     = done_q;
    err_d      = err_q;
    csum_total = sum_q + rx_data;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d = S_LEN;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          err_d   = 1'b0;
          timer_d = '0;
        end
      end
      S_LEN, S_DATA, S_CSUM: begin
        if (rx_valid) begin
          timer_d = '0;
          if (state_q == S_LEN) begin
            count_d = (rx_data == '0) ? (CW'(1) << ADDR_WIDTH) : CW'(rx_data);
            index_d = '0;
            sum_d   = '0;
            state_d = S_DATA;
          end else if (state_q == S_DATA) begin
            ram_we_d   = 1'b1;
            ram_addr_d = index_q[ADDR_WIDTH-1:0];
            ram_d_in_d = rx_data;
            sum_d      = csum_total;
            index_d    = index_q + CW'(1);
            if (index_q == count_q - CW'(1)) begin
              state_d = S_CSUM;
            end
          end else begin
            busy_d = 1'b0;
            if (csum_total == '0) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end else begin
              state_d = S_ERR;
              err_d   = 1'b1;
            end
          end
        end else if (timer_q == TIMER_LAST) begin
          state_d = S_ERR;
          busy_d  = 1'b0;
          err_d   = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      index_q    <= '0;
      sum_q      <= '0;
      timer_q    <= '0;
      ram_we_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_d_in_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      index_q    <= index_d;
      sum_q      <= sum_d;
      timer_q    <= timer_d;
      ram_we_q   <= ram_we_d;
      ram_addr_q <= ram_addr_d;
      ram_d_in_q <= ram_d_in_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign ram_we   = ram_we_q;
  assign ram_addr = ram_addr_q;
  assign ram_d_in = ram_d_in_q;
  assign busy     = busy_q;
  assign cpu_hold = busy_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule
